// File: rtl/alu_pkg.sv
// Shared ALU scheduler types: unit-select and shift sub-op codes, FSM states, command record.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int COUNT_WD = 4;

    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_CMP   = 2'b10,
        UNIT_SHIFT = 2'b11
    } unit_sel_e;

    // Shift sub-ops 00/01 act on operand A, 10/11 on operand B.
    typedef enum logic [1:0] {
        SH_OP_A0 = 2'b00,
        SH_OP_A1 = 2'b01,
        SH_OP_B0 = 2'b10,
        SH_OP_B1 = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef struct packed {
        unit_sel_e  sel;
        logic [1:0] fun;
    } cmd_t;

    function automatic logic shift_feeds_b(input logic [1:0] op);
        return (op == SH_OP_B0) || (op == SH_OP_B1);
    endfunction

    // Bit order: [0] arith, [1] logic, [2] cmp, [3] shift.
    function automatic logic [3:0] unit_onehot(input unit_sel_e s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/alu_issue_timer.sv
// Shift repeat down-counter and unit-response timeout up-counter with terminal flags.
// Latency: flags are combinational from registered counts, updated one cycle after a command.
// Backpressure: none; driven purely by the scheduler FSM strobes.
module alu_issue_timer
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                load,
    input  logic [COUNT_WD-1:0] load_cnt,
    input  logic                dec,
    input  logic                tmr_clr,
    input  logic                tmr_inc,
    output logic                last,
    output logic                timeout_hit
);

    localparam int TMR_WD = $clog2(TIMEOUT + 1);

    logic [COUNT_WD-1:0] rem_q;
    logic [TMR_WD-1:0]   tmr_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rem_q <= '0;
            tmr_q <= '0;
        end else begin
            if (load) begin
                rem_q <= load_cnt;
            end else if (dec) begin
                rem_q <= rem_q - COUNT_WD'(1);
            end

            if (load || tmr_clr) begin
                tmr_q <= '0;
            end else if (tmr_inc) begin
                tmr_q <= tmr_q + TMR_WD'(1);
            end
        end
    end

    assign last        = (rem_q <= COUNT_WD'(1));
    assign timeout_hit = (tmr_q == TMR_WD'(TIMEOUT));

endmodule

// File: rtl/alu_op_scheduler.sv
// Sequences one command at a time onto the ALU unit bank; multi-bit shifts loop single-bit passes.
// Latency: 2 cycles per unit pass (shift of N: 2N), timeout result TIMEOUT+2 cycles after accept.
// Backpressure: CMD_READY only in IDLE; result held in DONE until RES_READY.
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int IN_DATA_WD = 16,
    parameter int OUT_WD     = IN_DATA_WD,
    parameter int TIMEOUT    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [3:0]            CMD_FUN,
    input  logic [3:0]            CMD_CNT,
    input  logic [IN_DATA_WD-1:0] CMD_A,
    input  logic [IN_DATA_WD-1:0] CMD_B,
    output logic [IN_DATA_WD-1:0] UNIT_A,
    output logic [IN_DATA_WD-1:0] UNIT_B,
    output logic [1:0]            UNIT_FUN,
    output logic                  ARITH_EN,
    output logic                  LOGIC_EN,
    output logic                  CMP_EN,
    output logic                  SHIFT_EN,
    input  logic [OUT_WD-1:0]     ARITH_OUT,
    input  logic [OUT_WD-1:0]     LOGIC_OUT,
    input  logic [OUT_WD-1:0]     CMP_OUT,
    input  logic [OUT_WD-1:0]     SHIFT_OUT,
    input  logic                  ARITH_FLAG,
    input  logic                  LOGIC_FLAG,
    input  logic                  CMP_FLAG,
    input  logic                  SHIFT_FLAG,
    output logic                  RES_VALID,
    input  logic                  RES_READY,
    output logic [OUT_WD-1:0]     RES_DATA,
    output logic                  RES_ERR,
    output logic                  BUSY
);

    state_e                state_q, state_d;
    cmd_t                  cmd_q, cmd_d;
    logic [IN_DATA_WD-1:0] unit_a_q, unit_a_d;
    logic [IN_DATA_WD-1:0] unit_b_q, unit_b_d;
    logic [3:0]            en_q, en_d;
    logic                  res_vld_q, res_vld_d;
    logic [OUT_WD-1:0]     res_dat_q, res_dat_d;
    logic                  res_err_q, res_err_d;

    logic                  cnt_load, cnt_dec, tmr_clr, tmr_inc;
    logic                  cnt_last, timeout_hit;
    logic [COUNT_WD-1:0]   load_cnt;
    logic                  sel_flag;
    logic [OUT_WD-1:0]     sel_out;
    logic [IN_DATA_WD-1:0] shift_fb;

    alu_issue_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .CLK         (CLK),
        .RST         (RST),
        .load        (cnt_load),
        .load_cnt    (load_cnt),
        .dec         (cnt_dec),
        .tmr_clr     (tmr_clr),
        .tmr_inc     (tmr_inc),
        .last        (cnt_last),
        .timeout_hit (timeout_hit)
    );

    // Non-shift commands and a zero count both mean a single pass.
    always_comb begin
        load_cnt = COUNT_WD'(1);
        if ((CMD_FUN[3:2] == UNIT_SHIFT) && (CMD_CNT != '0)) begin
            load_cnt = CMD_CNT;
        end
    end

    always_comb begin
        sel_flag = ARITH_FLAG;
        sel_out  = ARITH_OUT;
        case (cmd_q.sel)
            UNIT_ARITH: begin sel_flag = ARITH_FLAG; sel_out = ARITH_OUT; end
            UNIT_LOGIC: begin sel_flag = LOGIC_FLAG; sel_out = LOGIC_OUT; end
            UNIT_CMP:   begin sel_flag = CMP_FLAG;   sel_out = CMP_OUT;   end
            UNIT_SHIFT: begin sel_flag = SHIFT_FLAG; sel_out = SHIFT_OUT; end
            default:    begin sel_flag = ARITH_FLAG; sel_out = ARITH_OUT; end
        endcase
    end

    assign shift_fb = IN_DATA_WD'(SHIFT_OUT);

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        unit_a_d  = unit_a_q;
        unit_b_d  = unit_b_q;
        en_d      = '0;
        res_vld_d = res_vld_q;
        res_dat_d = res_dat_q;
        res_err_d = res_err_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    cmd_d    = '{sel: unit_sel_e'(CMD_FUN[3:2]), fun: CMD_FUN[1:0]};
                    unit_a_d = CMD_A;
                    unit_b_d = CMD_B;
                    en_d     = unit_onehot(unit_sel_e'(CMD_FUN[3:2]));
                    cnt_load = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmr_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sel_flag) begin
                    if (!cnt_last) begin
                        // Only shifts carry a count above one: loop the partial result back.
                        if (shift_feeds_b(cmd_q.fun)) begin
                            unit_b_d = shift_fb;
                        end else begin
                            unit_a_d = shift_fb;
                        end
                        cnt_dec = 1'b1;
                        en_d    = unit_onehot(cmd_q.sel);
                        state_d = ST_ISSUE;
                    end else begin
                        res_dat_d = sel_out;
                        res_err_d = 1'b0;
                        res_vld_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end else if (timeout_hit) begin
                    res_dat_d = '0;
                    res_err_d = 1'b1;
                    res_vld_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ST_DONE: begin
                if (RES_READY) begin
                    res_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            unit_a_q  <= '0;
            unit_b_q  <= '0;
            en_q      <= '0;
            res_vld_q <= 1'b0;
            res_dat_q <= '0;
            res_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            unit_a_q  <= unit_a_d;
            unit_b_q  <= unit_b_d;
            en_q      <= en_d;
            res_vld_q <= res_vld_d;
            res_dat_q <= res_dat_d;
            res_err_q <= res_err_d;
        end
    end

    assign CMD_READY = (state_q == ST_IDLE);
    assign BUSY      = (state_q != ST_IDLE);
    assign UNIT_A    = unit_a_q;
    assign UNIT_B    = unit_b_q;
    assign UNIT_FUN  = cmd_q.fun;
    assign ARITH_EN  = en_q[0];
    assign LOGIC_EN  = en_q[1];
    assign CMP_EN    = en_q[2];
    assign SHIFT_EN  = en_q[3];
    assign RES_VALID = res_vld_q;
    assign RES_DATA  = res_dat_q;
    assign RES_ERR   = res_err_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with behavioural unit-bank models.
// Table of single commands plus hand sequences for reset, operand feedback and backpressure.
module tb_alu_op_scheduler;

    localparam int WD  = 16;
    localparam int TMO = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic [3:0]    CMD_FUN = '0;
    logic [3:0]    CMD_CNT = '0;
    logic [WD-1:0] CMD_A = '0;
    logic [WD-1:0] CMD_B = '0;
    logic [WD-1:0] UNIT_A, UNIT_B;
    logic [1:0]    UNIT_FUN;
    logic          ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN;
    logic [WD-1:0] ARITH_OUT, LOGIC_OUT, CMP_OUT, SHIFT_OUT;
    logic          ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG;
    logic          RES_VALID;
    logic          RES_READY = 1'b0;
    logic [WD-1:0] RES_DATA;
    logic          RES_ERR;
    logic          BUSY;

    always #5 CLK = ~CLK;

    alu_op_scheduler #(.IN_DATA_WD(WD), .OUT_WD(WD), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_FUN(CMD_FUN), .CMD_CNT(CMD_CNT),
        .CMD_A(CMD_A), .CMD_B(CMD_B),
        .UNIT_A(UNIT_A), .UNIT_B(UNIT_B), .UNIT_FUN(UNIT_FUN),
        .ARITH_EN(ARITH_EN), .LOGIC_EN(LOGIC_EN), .CMP_EN(CMP_EN), .SHIFT_EN(SHIFT_EN),
        .ARITH_OUT(ARITH_OUT), .LOGIC_OUT(LOGIC_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
        .ARITH_FLAG(ARITH_FLAG), .LOGIC_FLAG(LOGIC_FLAG), .CMP_FLAG(CMP_FLAG), .SHIFT_FLAG(SHIFT_FLAG),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_ERR(RES_ERR),
        .BUSY(BUSY)
    );

    // Unit bank: result and flag registered one cycle after enable, zero otherwise.
    logic          cmp_dead = 1'b0;
    logic          noise    = 1'b0;
    logic [WD-1:0] ar_q = '0, lg_q = '0, cp_q = '0, sh_q = '0;
    logic          ar_f = 1'b0, lg_f = 1'b0, cp_f = 1'b0, sh_f = 1'b0;

    always @(posedge CLK) begin
        ar_f <= ARITH_EN;
        lg_f <= LOGIC_EN;
        cp_f <= CMP_EN;
        sh_f <= SHIFT_EN;
        ar_q <= '0; lg_q <= '0; cp_q <= '0; sh_q <= '0;
        if (ARITH_EN) ar_q <= (UNIT_FUN == 2'b01) ? UNIT_A - UNIT_B : UNIT_A + UNIT_B;
        if (LOGIC_EN) begin
            case (UNIT_FUN)
                2'b00:   lg_q <= UNIT_A & UNIT_B;
                2'b01:   lg_q <= UNIT_A | UNIT_B;
                2'b10:   lg_q <= UNIT_A ^ UNIT_B;
                default: lg_q <= ~UNIT_A;
            endcase
        end
        if (CMP_EN) begin
            case (UNIT_FUN)
                2'b00:   cp_q <= {15'd0, UNIT_A < UNIT_B};
                2'b01:   cp_q <= {15'd0, UNIT_A == UNIT_B};
                2'b10:   cp_q <= {15'd0, UNIT_A > UNIT_B};
                default: cp_q <= {15'd0, UNIT_A != UNIT_B};
            endcase
        end
        if (SHIFT_EN) begin
            case (UNIT_FUN)
                2'b00:   sh_q <= UNIT_A >> 1;
                2'b01:   sh_q <= UNIT_A << 1;
                2'b10:   sh_q <= UNIT_B >> 1;
                default: sh_q <= UNIT_B << 1;
            endcase
        end
    end

    assign ARITH_OUT  = ar_q;
    assign LOGIC_OUT  = lg_q;
    assign CMP_OUT    = cp_q;
    assign SHIFT_OUT  = sh_q;
    assign ARITH_FLAG = ar_f | noise;
    assign LOGIC_FLAG = lg_f | noise;
    assign CMP_FLAG   = cp_f & ~cmp_dead;
    assign SHIFT_FLAG = sh_f | noise;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  fun;
        logic [3:0]  cnt;
        logic [15:0] a;
        logic [15:0] b;
        logic        dead;
        logic        nse;
        logic [15:0] exp_dat;
        logic        exp_err;
        int          exp_lat;
        int          exp_pass;
    } vec_t;

    vec_t          vecs[12];
    int            pulses[4];
    int            multi;
    int            nops;
    logic [WD-1:0] seen_ops[16];
    int            lat;

    // Issue one command, watch enables each cycle, stop when a result is held.
    task automatic do_cmd(input logic [3:0] fun, input logic [3:0] cnt,
                          input logic [WD-1:0] a, input logic [WD-1:0] b);
        int n;
        for (int u = 0; u < 4; u++) pulses[u] = 0;
        multi = 0;
        nops  = 0;
        lat   = -1;
        CMD_FUN = fun; CMD_CNT = cnt; CMD_A = a; CMD_B = b;
        CMD_VALID = 1'b1;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        for (int c = 0; c < 64; c++) begin
            n = int'(ARITH_EN) + int'(LOGIC_EN) + int'(CMP_EN) + int'(SHIFT_EN);
            if (n > 1) multi++;
            if (ARITH_EN) pulses[0]++;
            if (LOGIC_EN) pulses[1]++;
            if (CMP_EN)   pulses[2]++;
            if (SHIFT_EN) begin
                pulses[3]++;
                if (nops < 16) seen_ops[nops] = fun[1] ? UNIT_B : UNIT_A;
                nops++;
            end
            if (RES_VALID) begin
                lat = c;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic take_result();
        RES_READY = 1'b1;
        @(posedge CLK); #1;
        RES_READY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int            others;
        logic [WD-1:0] held;
        int            seen_vld;
        int            sel;

        vecs[0]  = '{4'h0, 4'h9, 16'd5,    16'd7,    1'b0, 1'b0, 16'd12,   1'b0, 2,       1};
        vecs[1]  = '{4'h1, 4'h0, 16'h0010, 16'h0011, 1'b0, 1'b0, 16'hFFFF, 1'b0, 2,       1};
        vecs[2]  = '{4'h4, 4'h3, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 16'h00F0, 1'b0, 2,       1};
        vecs[3]  = '{4'h6, 4'h0, 16'hFFFF, 16'h00FF, 1'b0, 1'b0, 16'hFF00, 1'b0, 2,       1};
        vecs[4]  = '{4'h8, 4'h0, 16'd3,    16'd7,    1'b0, 1'b1, 16'h0001, 1'b0, 2,       1};
        vecs[5]  = '{4'hD, 4'h0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0006, 1'b0, 2,       1};
        vecs[6]  = '{4'hE, 4'h4, 16'h0000, 16'h8000, 1'b0, 1'b0, 16'h0800, 1'b0, 8,       4};
        vecs[7]  = '{4'hD, 4'hF, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h8000, 1'b0, 30,      15};
        vecs[8]  = '{4'hC, 4'hF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 30,      15};
        vecs[9]  = '{4'hF, 4'h1, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 2,       1};
        vecs[10] = '{4'h9, 4'h0, 16'd3,    16'd7,    1'b1, 1'b1, 16'h0000, 1'b1, TMO + 2, 1};
        vecs[11] = '{4'h5, 4'h7, 16'h1200, 16'h0034, 1'b0, 1'b0, 16'h1234, 1'b0, 2,       1};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy",      {31'd0, BUSY},      32'd0);
        chk("rst_cmd_ready", {31'd0, CMD_READY}, 32'd1);
        chk("rst_res_valid", {31'd0, RES_VALID}, 32'd0);
        chk("rst_en",        {28'd0, ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, 32'd0);
        chk("rst_unit_ops",  {UNIT_A, UNIT_B},   32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("post_rst_res",  {15'd0, RES_ERR, RES_DATA}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            cmp_dead = vecs[i].dead;
            noise    = vecs[i].nse;
            do_cmd(vecs[i].fun, vecs[i].cnt, vecs[i].a, vecs[i].b);
            sel    = int'(vecs[i].fun[3:2]);
            others = pulses[0] + pulses[1] + pulses[2] + pulses[3] - pulses[sel];
            chk($sformatf("v%0d_latency", i), lat,               vecs[i].exp_lat);
            chk($sformatf("v%0d_data", i),    {16'd0, RES_DATA}, {16'd0, vecs[i].exp_dat});
            chk($sformatf("v%0d_err", i),     {31'd0, RES_ERR},  {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_sel_pulses", i),   pulses[sel], vecs[i].exp_pass);
            chk($sformatf("v%0d_other_pulses", i), others,      0);
            chk($sformatf("v%0d_onehot", i),       multi,       0);
            take_result();
            chk($sformatf("v%0d_release", i), {30'd0, RES_VALID, CMD_READY}, 32'd1);
            cmp_dead = 1'b0;
            noise    = 1'b0;
        end

        // Repeat shift: operand fed back on B each pass
        do_cmd(4'hE, 4'h4, 16'h0000, 16'h8000);
        chk("fb_passes", nops, 4);
        chk("fb_op0", {16'd0, seen_ops[0]}, 32'h8000);
        chk("fb_op1", {16'd0, seen_ops[1]}, 32'h4000);
        chk("fb_op2", {16'd0, seen_ops[2]}, 32'h2000);
        chk("fb_op3", {16'd0, seen_ops[3]}, 32'h1000);
        chk("fb_result", {16'd0, RES_DATA}, 32'h0800);
        take_result();

        // Backpressure: result held while consumer stalls and next command waits
        do_cmd(4'h0, 4'h0, 16'd5, 16'd7);
        held = RES_DATA;
        chk("bp_first", {16'd0, held}, 32'd12);
        CMD_FUN = 4'h5; CMD_CNT = 4'h0; CMD_A = 16'h0001; CMD_B = 16'h0002;
        CMD_VALID = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #1;
            chk($sformatf("bp_hold_vld_%0d", c), {31'd0, RES_VALID}, 32'd1);
            chk($sformatf("bp_hold_dat_%0d", c), {16'd0, RES_DATA},  {16'd0, held});
            chk($sformatf("bp_hold_rdy_%0d", c), {31'd0, CMD_READY}, 32'd0);
        end
        RES_READY = 1'b1;
        @(posedge CLK); #1;
        RES_READY = 1'b0;
        chk("bp_drop_vld", {31'd0, RES_VALID}, 32'd0);
        chk("bp_cmd_rdy",  {31'd0, CMD_READY}, 32'd1);
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        chk("bp_accept_busy", {31'd0, BUSY},     32'd1);
        chk("bp_accept_en",   {31'd0, LOGIC_EN}, 32'd1);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("bp_second_vld", {31'd0, RES_VALID}, 32'd1);
        chk("bp_second_dat", {16'd0, RES_DATA},  32'h0003);
        take_result();

        // Reset in the middle of a 5-pass shift
        CMD_FUN = 4'hD; CMD_CNT = 4'h5; CMD_A = 16'h0001; CMD_B = 16'h0000;
        CMD_VALID = 1'b1;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        repeat (3) begin
            @(posedge CLK); #1;
        end
        chk("mid_busy", {31'd0, BUSY}, 32'd1);
        RST = 1'b0;
        #1;
        chk("arst_busy",  {31'd0, BUSY},      32'd0);
        chk("arst_en",    {28'd0, ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN}, 32'd0);
        chk("arst_ops",   {UNIT_A, UNIT_B},   32'd0);
        chk("arst_fun",   {30'd0, UNIT_FUN},  32'd0);
        chk("arst_res",   {14'd0, RES_VALID, RES_ERR, RES_DATA}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        RES_READY = 1'b1;
        seen_vld = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge CLK); #1;
            if (RES_VALID || BUSY) seen_vld++;
        end
        RES_READY = 1'b0;
        chk("arst_no_result", seen_vld, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
